// File: rtl/jtframe_dwnld_pack.sv
// Packs SPI download bytes into 16-bit masked words and queues them for the
// SDRAM programming port behind a req/ack handshake.
module jtframe_dwnld_pack #(
    parameter int unsigned AW    = 22,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_data,
    input  logic          ioctl_wr,
    output logic [AW-2:0] prog_addr,
    output logic [15:0]   prog_data,
    output logic [1:0]    prog_mask,
    output logic          prog_we,
    input  logic          prog_rdy,
    output logic          busy,
    output logic          overflow
);

    localparam int unsigned WAW = AW - 1;
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = PW + 1;

    typedef struct packed {
        logic [WAW-1:0] addr;
        logic [15:0]    data;
        logic [1:0]     mask;
    } word_t;

    typedef enum logic {ST_EMPTY, ST_HALF} state_t;

    localparam word_t IDLE_WORD = '{addr: '0, data: '0, mask: 2'b11};

    state_t         r_state, w_state_nx;
    logic [WAW-1:0] r_hold_addr;
    logic [7:0]     r_hold_data;
    logic           r_skid_vld;
    word_t          r_skid;
    word_t          r_mem [DEPTH];
    logic [PW-1:0]  r_wp, r_rp;
    logic [CW-1:0]  r_cnt;
    logic           r_ovf;
    logic           r_dl_q;

    logic           w_acc, w_odd, w_same;
    logic [WAW-1:0] w_waddr;
    word_t          w_in, w_hold, w_merged;
    logic           w_p_vld, w_s_vld, w_hold_ld;
    word_t          w_p, w_s;
    logic           w_push, w_skid_nx_vld;
    word_t          w_push_word, w_skid_nx;
    logic           w_pop, w_full, w_wr;

    assign w_acc   = downloading && ioctl_wr;
    assign w_odd   = ioctl_addr[0];
    assign w_waddr = ioctl_addr[AW-1:1];
    assign w_same  = (w_waddr == r_hold_addr);

    always_comb begin
        w_in.addr     = w_waddr;
        w_in.data     = w_odd ? {ioctl_data, 8'h00} : {8'h00, ioctl_data};
        w_in.mask     = w_odd ? 2'b01 : 2'b10;
        w_hold.addr   = r_hold_addr;
        w_hold.data   = {8'h00, r_hold_data};
        w_hold.mask   = 2'b10;
        w_merged.addr = r_hold_addr;
        w_merged.data = {ioctl_data, r_hold_data};
        w_merged.mask = 2'b00;
    end

    // Pairing FSM: decides what to push this cycle and what spills to the skid
    always_comb begin
        w_state_nx = r_state;
        w_p_vld    = 1'b0;
        w_p        = IDLE_WORD;
        w_s_vld    = 1'b0;
        w_s        = IDLE_WORD;
        w_hold_ld  = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_acc) begin
                    if (w_odd) begin
                        w_p_vld = 1'b1;
                        w_p     = w_in;
                    end else begin
                        w_hold_ld  = 1'b1;
                        w_state_nx = ST_HALF;
                    end
                end
            end
            ST_HALF: begin
                if (w_acc) begin
                    w_p_vld = 1'b1;
                    if (w_odd && w_same) begin
                        w_p        = w_merged;
                        w_state_nx = ST_EMPTY;
                    end else begin
                        w_p = w_hold;
                        if (!w_odd) begin
                            w_hold_ld = 1'b1;
                        end else begin
                            w_s_vld    = 1'b1;
                            w_s        = w_in;
                            w_state_nx = ST_EMPTY;
                        end
                    end
                end else if (!downloading) begin
                    w_p_vld    = 1'b1;
                    w_p        = w_hold;
                    w_state_nx = ST_EMPTY;
                end
            end
            default: w_state_nx = ST_EMPTY;
        endcase
    end

    // A pending skid word always goes first; the fresh push takes its place
    always_comb begin
        if (r_skid_vld) begin
            w_push        = 1'b1;
            w_push_word   = r_skid;
            w_skid_nx_vld = w_p_vld;
            w_skid_nx     = w_p;
        end else begin
            w_push        = w_p_vld;
            w_push_word   = w_p;
            w_skid_nx_vld = w_s_vld;
            w_skid_nx     = w_s;
        end
    end

    assign w_pop  = (r_cnt != '0) && prog_rdy;
    assign w_full = (r_cnt == CW'(DEPTH));
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_addr <= '0;
            r_hold_data <= '0;
            r_skid_vld  <= 1'b0;
            r_skid      <= IDLE_WORD;
            r_ovf       <= 1'b0;
            r_dl_q      <= 1'b0;
        end else begin
            if (w_hold_ld) begin
                r_hold_addr <= w_waddr;
                r_hold_data <= ioctl_data;
            end
            r_skid_vld <= w_skid_nx_vld;
            r_skid     <= w_skid_nx;
            r_dl_q     <= downloading;
            if (downloading && !r_dl_q) r_ovf <= 1'b0;
            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    // Word FIFO; a write into a full FIFO is legal when the head pops this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= IDLE_WORD;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= w_push_word;
                r_wp        <= r_wp + PW'(1);
            end
            if (w_pop) r_rp <= r_rp + PW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign prog_we   = (r_cnt != '0);
    assign prog_addr = r_mem[r_rp].addr;
    assign prog_data = r_mem[r_rp].data;
    assign prog_mask = r_mem[r_rp].mask;
    assign overflow  = r_ovf;
    assign busy      = downloading || (r_state == ST_HALF) || r_skid_vld || prog_we;

endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
// Directed bench for jtframe_dwnld_pack: byte pairing, flush, back-pressure,
// overflow, full push/pop and mid-download reset.
module tb_jtframe_dwnld_pack;

    logic        clk;
    logic        rst;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic [20:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prog_rdy;
    logic        busy;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    jtframe_dwnld_pack #(.AW(22), .DEPTH(4)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_we     (prog_we),
        .prog_rdy    (prog_rdy),
        .busy        (busy),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [21:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic head(input string tag, input logic [20:0] a, input logic [15:0] d,
                        input logic [1:0] m);
        chk({tag, ".we"},   32'(prog_we),   32'(1));
        chk({tag, ".addr"}, 32'(prog_addr), 32'(a));
        chk({tag, ".data"}, 32'(prog_data), 32'(d));
        chk({tag, ".mask"}, 32'(prog_mask), 32'(m));
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1; downloading = 1'b0; ioctl_addr = '0; ioctl_data = '0;
        ioctl_wr = 1'b0; prog_rdy = 1'b0;
        tick(); tick();
        chk("rst.we",   32'(prog_we),   32'(0));
        chk("rst.addr", 32'(prog_addr), 32'(0));
        chk("rst.data", 32'(prog_data), 32'(0));
        chk("rst.mask", 32'(prog_mask), 32'(3));
        chk("rst.busy", 32'(busy),      32'(0));
        chk("rst.ovf",  32'(overflow),  32'(0));
        rst = 1'b0;

        // sequential bytes, controller always ready
        downloading = 1'b1; prog_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = 8'(8'h11 * (i + 1));
            send(22'(i), b);
            if (i % 2 == 1)
                head($sformatf("seq%0d", i), 21'(i / 2), {b, 8'(8'h11 * i)}, 2'b00);
            else
                chk($sformatf("seq%0d.we", i), 32'(prog_we), 32'(0));
        end
        downloading = 1'b0;
        tick();
        chk("seq.busy", 32'(busy), 32'(0));

        // odd length with flush on download end
        downloading = 1'b1;
        send(22'd0, 8'hA0);
        send(22'd1, 8'hA1);
        head("odd.w0", 21'd0, 16'hA1A0, 2'b00);
        send(22'd2, 8'hA2);
        chk("odd.gap", 32'(prog_we), 32'(0));
        downloading = 1'b0;
        tick();
        head("odd.flush", 21'd1, 16'h00A2, 2'b10);
        tick();
        chk("odd.we_end", 32'(prog_we), 32'(0));
        chk("odd.busy",   32'(busy),    32'(0));

        // back-pressure and overflow
        downloading = 1'b1; prog_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(22'(i), 8'(8'hB0 + i));
            if (i == 1) head("bp.first", 21'd0, 16'hB1B0, 2'b00);
        end
        head("bp.full", 21'd0, 16'hB1B0, 2'b00);
        chk("bp.ovf0", 32'(overflow), 32'(0));
        chk("bp.busy", 32'(busy),     32'(1));
        send(22'd8, 8'hB8);
        send(22'd9, 8'hB9);
        chk("bp.ovf1", 32'(overflow), 32'(1));
        head("bp.held", 21'd0, 16'hB1B0, 2'b00);
        prog_rdy = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            head($sformatf("bp.drain%0d", k), 21'(k),
                 {8'(8'hB0 + 2 * k + 1), 8'(8'hB0 + 2 * k)}, 2'b00);
        end
        tick();
        chk("bp.empty", 32'(prog_we), 32'(0));
        downloading = 1'b0;
        tick();

        // non-sequential addresses
        downloading = 1'b1; prog_rdy = 1'b0;
        send(22'h10, 8'hC0);
        chk("ns.ovf_clr", 32'(overflow), 32'(0));
        chk("ns.we0",     32'(prog_we),  32'(0));
        send(22'h21, 8'hC1);
        head("ns.w0", 21'h08, 16'h00C0, 2'b10);
        send(22'h40, 8'hC2);
        head("ns.w0hold", 21'h08, 16'h00C0, 2'b10);
        prog_rdy = 1'b1;
        tick();
        head("ns.w1", 21'h10, 16'hC100, 2'b01);
        tick();
        chk("ns.we_gap", 32'(prog_we), 32'(0));
        chk("ns.busy_h", 32'(busy),    32'(1));
        downloading = 1'b0;
        tick();
        head("ns.flush", 21'h20, 16'h00C2, 2'b10);
        tick();
        chk("ns.we_end", 32'(prog_we), 32'(0));
        chk("ns.busy",   32'(busy),    32'(0));

        // push and pop in the same cycle while full
        downloading = 1'b1; prog_rdy = 1'b0;
        for (int i = 0; i < 9; i++) send(22'(i), 8'(8'hD0 + i));
        prog_rdy = 1'b1;
        send(22'd9, 8'hD9);
        chk("pp.ovf", 32'(overflow), 32'(0));
        head("pp.h1", 21'd1, 16'hD3D2, 2'b00);
        tick();
        head("pp.h2", 21'd2, 16'hD5D4, 2'b00);
        tick();
        head("pp.h3", 21'd3, 16'hD7D6, 2'b00);
        tick();
        head("pp.h4", 21'd4, 16'hD9D8, 2'b00);
        tick();
        chk("pp.empty", 32'(prog_we), 32'(0));
        downloading = 1'b0;
        tick();
        chk("pp.busy", 32'(busy), 32'(0));

        // reset while HALF with a queued word
        downloading = 1'b1; prog_rdy = 1'b0;
        send(22'd0, 8'hE0);
        send(22'd1, 8'hE1);
        send(22'd2, 8'hE2);
        head("rh.pre", 21'd0, 16'hE1E0, 2'b00);
        rst = 1'b1;
        tick();
        chk("rh.we",   32'(prog_we),   32'(0));
        chk("rh.mask", 32'(prog_mask), 32'(3));
        chk("rh.data", 32'(prog_data), 32'(0));
        rst = 1'b0; downloading = 1'b0;
        tick();
        chk("rh.noflush", 32'(prog_we), 32'(0));
        chk("rh.busy",    32'(busy),    32'(0));
        tick();
        chk("rh.still", 32'(prog_we), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
